// File: rtl/dmem_store_logger_if.sv
// MEM-stage store/load bus plus the store-trace drain port of dmem_store_logger.
// The master side is the pipeline/checker; the slave side is the data memory.
interface dmem_store_logger_if #(
  parameter int LOG_DEPTH = 16
) ();
  localparam int CNT_W = $clog2(LOG_DEPTH + 1);

  logic             memwrite;
  logic             memread;
  logic [31:0]      dataadr;
  logic [31:0]      writedata;
  logic [2:0]       funct3;
  logic [31:0]      readdata;
  logic             misaligned;
  logic             log_valid;
  logic             log_ready;
  logic [31:0]      log_addr;
  logic [31:0]      log_data;
  logic [CNT_W-1:0] log_count;
  logic             log_overflow;

  modport master (
    output memwrite, memread, dataadr, writedata, funct3, log_ready,
    input  readdata, misaligned, log_valid, log_addr, log_data, log_count, log_overflow
  );

  modport slave (
    input  memwrite, memread, dataadr, writedata, funct3, log_ready,
    output readdata, misaligned, log_valid, log_addr, log_data, log_count, log_overflow
  );
endinterface

// File: rtl/dmem_store_logger.sv
// Data memory for the MEM stage that also queues every committed store in a trace FIFO.
// Optional feature macro: DMEM_TOHOST_EN adds a tohost register that captures word stores.
module dmem_store_logger #(
  parameter int DEPTH_WORDS = 64,
  parameter int LOG_DEPTH   = 16
`ifdef DMEM_TOHOST_EN
  , parameter logic [31:0] TOHOST_ADDR = 32'h000000FC
`endif
) (
  input  logic clk,
  input  logic rst_n,
  dmem_store_logger_if.slave bus
`ifdef DMEM_TOHOST_EN
  , output logic        tohost_done
  , output logic [31:0] tohost_code
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = $clog2(LOG_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LOG_DEPTH);

  logic [31:0] mem_q     [DEPTH_WORDS];
  logic [31:0] logAddr_q [LOG_DEPTH];
  logic [31:0] logData_q [LOG_DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [IDX_W-1:0] wordIdx;
  logic [1:0]       lane;
  logic             isHalf;
  logic             isWord;
  logic             misaligned;
  logic             storeCommit;
  logic             tohostHit;
  logic             arrayWrite;
  logic [3:0]       byteEn;
  logic [31:0]      laneData;
  logic [31:0]      sizeMask;
  logic [31:0]      rdWord;
  logic [7:0]       rdByte;
  logic [15:0]      rdHalf;
  logic [31:0]      readdata;
  logic             logValid;
  logic             pop;
  logic             full;
  logic             push;

  assign wordIdx = bus.dataadr[IDX_W+1:2];
  assign lane    = bus.dataadr[1:0];
  assign isHalf  = (bus.funct3[1:0] == 2'b01);
  assign isWord  = bus.funct3[1];

  assign misaligned = (bus.memwrite | bus.memread) &
                      ((isHalf & lane[0]) | (isWord & (lane != 2'b00)));
  assign storeCommit = bus.memwrite & ~misaligned;

`ifdef DMEM_TOHOST_EN
  logic        tohostDone_q, tohostDone_d;
  logic [31:0] tohostCode_q, tohostCode_d;

  assign tohostHit = storeCommit & isWord & (bus.dataadr == TOHOST_ADDR);

  always_comb begin
    tohostDone_d = tohostDone_q;
    tohostCode_d = tohostCode_q;
    if (tohostHit) begin
      tohostDone_d = 1'b1;
      tohostCode_d = bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tohostDone_q <= 1'b0;
      tohostCode_q <= 32'h0;
    end else begin
      tohostDone_q <= tohostDone_d;
      tohostCode_q <= tohostCode_d;
    end
  end

  assign tohost_done = tohostDone_q;
  assign tohost_code = tohostCode_q;
`else
  assign tohostHit = 1'b0;
`endif

  assign arrayWrite = storeCommit & ~tohostHit;

  // Store data arrives unshifted, so replicate it across lanes and let byteEn pick.
  always_comb begin
    byteEn   = 4'b0000;
    laneData = 32'h0;
    sizeMask = 32'h0;
    if (isWord) begin
      byteEn   = 4'b1111;
      laneData = bus.writedata;
      sizeMask = 32'hFFFF_FFFF;
    end else if (isHalf) begin
      byteEn   = lane[1] ? 4'b1100 : 4'b0011;
      laneData = {2{bus.writedata[15:0]}};
      sizeMask = 32'h0000_FFFF;
    end else begin
      byteEn   = 4'b0001 << lane;
      laneData = {4{bus.writedata[7:0]}};
      sizeMask = 32'h0000_00FF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && arrayWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem_q[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
        end
      end
    end
  end

  assign rdWord = mem_q[wordIdx];
  assign rdHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    rdByte = rdWord[7:0];
    case (lane)
      2'd1:    rdByte = rdWord[15:8];
      2'd2:    rdByte = rdWord[23:16];
      2'd3:    rdByte = rdWord[31:24];
      default: rdByte = rdWord[7:0];
    endcase
  end

  always_comb begin
    readdata = 32'h0;
    if (bus.memread && !misaligned) begin
      case (bus.funct3)
        3'b000:  readdata = {{24{rdByte[7]}}, rdByte};
        3'b001:  readdata = {{16{rdHalf[15]}}, rdHalf};
        3'b010:  readdata = rdWord;
        3'b100:  readdata = {24'h0, rdByte};
        3'b101:  readdata = {16'h0, rdHalf};
        default: readdata = 32'h0;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign logValid = (count_q != '0);
  assign pop      = logValid & bus.log_ready;
  assign full     = (count_q == FULL_CNT);
  assign push     = arrayWrite & (~full | pop);

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (arrayWrite && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      logAddr_q[wrPtr_q] <= bus.dataadr;
      logData_q[wrPtr_q] <= bus.writedata & sizeMask;
    end
  end

  assign bus.readdata     = readdata;
  assign bus.misaligned   = misaligned;
  assign bus.log_valid    = logValid;
  assign bus.log_addr     = logAddr_q[rdPtr_q];
  assign bus.log_data     = logData_q[rdPtr_q];
  assign bus.log_count    = count_q;
  assign bus.log_overflow = overflow_q;

endmodule

// File: tb/tb_dmem_store_logger.sv
// Self-checking bench for dmem_store_logger: byte-array/queue reference model plus directed vectors.
// Define DMEM_TOHOST_EN for both bench and RTL to exercise the tohost register.
module tb_dmem_store_logger;

  localparam int DEPTH_WORDS = 64;
  localparam int LOG_DEPTH   = 16;
  localparam int MEM_BYTES   = DEPTH_WORDS * 4;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_store_logger_if #(.LOG_DEPTH(LOG_DEPTH)) bus ();

`ifdef DMEM_TOHOST_EN
  logic        tohostDone;
  logic [31:0] tohostCode;
`endif

  dmem_store_logger #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LOG_DEPTH  (LOG_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DMEM_TOHOST_EN
    , .tohost_done(tohostDone)
    , .tohost_code(tohostCode)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } logEntry_t;

  logEntry_t   modelQ[$];
  logic [7:0]  modelMem [MEM_BYTES];
  bit          modelOvf  = 1'b0;
  bit          modelLive = 1'b0;
  bit          modelDone = 1'b0;
  logic [31:0] modelCode = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sizeBytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit expMisaligned(input bit we, input bit re, input logic [31:0] a,
                                       input logic [2:0] f3);
    if (!(we || re)) return 1'b0;
    return (a % sizeBytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] expRead(input bit we, input bit re, input logic [31:0] a,
                                          input logic [2:0] f3);
    int unsigned base;
    longint v;
    if (!re || expMisaligned(we, re, a, f3)) return 32'h0;
    base = a % MEM_BYTES;
    v = 0;
    for (int k = sizeBytes(f3) - 1; k >= 0; k--) v = v * 256 + modelMem[(base + k) % MEM_BYTES];
    case (f3)
      F_B:     if (v > 127)   v = v - 256;
      F_H:     if (v > 32767) v = v - 65536;
      F_W, F_BU, F_HU: ;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Reference model: commits on the rising edge using the inputs held over the cycle.
  bit          popNow;
  bit          pushReq;
  bit          wasFull;
  int unsigned baseAddr;
  logEntry_t   newEntry;

  always @(posedge clk) begin
    if (!rst_n) begin
      modelQ.delete();
      modelOvf  = 1'b0;
      modelDone = 1'b0;
      modelCode = 32'h0;
      modelLive = 1'b1;
    end else begin
      popNow  = (modelQ.size() != 0) && bus.log_ready;
      wasFull = (modelQ.size() == LOG_DEPTH);
      pushReq = 1'b0;
      if (bus.memwrite && !expMisaligned(1'b1, bus.memread, bus.dataadr, bus.funct3)) begin
        pushReq = 1'b1;
`ifdef DMEM_TOHOST_EN
        if (bus.funct3 == F_W && bus.dataadr == 32'h000000FC) begin
          pushReq   = 1'b0;
          modelDone = 1'b1;
          modelCode = bus.writedata;
        end
`endif
        if (pushReq) begin
          baseAddr = bus.dataadr % MEM_BYTES;
          for (int k = 0; k < sizeBytes(bus.funct3); k++)
            modelMem[(baseAddr + k) % MEM_BYTES] = 8'(bus.writedata >> (8 * k));
          newEntry.addr = bus.dataadr;
          newEntry.data = 32'(bus.writedata % (64'd1 << (8 * sizeBytes(bus.funct3))));
        end
      end
      if (popNow) void'(modelQ.pop_front());
      if (pushReq) begin
        if (!wasFull || popNow) modelQ.push_back(newEntry);
        else modelOvf = 1'b1;
      end
    end
  end

  // Compare process: every mid-cycle, all outputs against the model.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("cmpMisaligned", 32'(bus.misaligned),
                  32'(expMisaligned(bus.memwrite, bus.memread, bus.dataadr, bus.funct3)));
      checkOutput("cmpReaddata", bus.readdata,
                  expRead(bus.memwrite, bus.memread, bus.dataadr, bus.funct3));
      checkOutput("cmpLogValid", 32'(bus.log_valid), 32'(modelQ.size() != 0));
      checkOutput("cmpLogCount", 32'(bus.log_count), 32'(modelQ.size()));
      checkOutput("cmpOverflow", 32'(bus.log_overflow), 32'(modelOvf));
      if (modelQ.size() != 0) begin
        checkOutput("cmpLogAddr", bus.log_addr, modelQ[0].addr);
        checkOutput("cmpLogData", bus.log_data, modelQ[0].data);
      end
`ifdef DMEM_TOHOST_EN
      checkOutput("cmpTohostDone", 32'(tohostDone), 32'(modelDone));
      checkOutput("cmpTohostCode", tohostCode, modelCode);
`endif
    end
  end

  task automatic applyStimulus(input bit we, input bit re, input logic [31:0] a,
                               input logic [31:0] wd, input logic [2:0] f3, input bit rdy);
    @(posedge clk);
    #1;
    bus.memwrite  = we;
    bus.memread   = re;
    bus.dataadr   = a;
    bus.writedata = wd;
    bus.funct3    = f3;
    bus.log_ready = rdy;
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, F_W, rdy);
  endtask

  initial begin
    #2_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  int pops;

  initial begin
    bus.memwrite  = 1'b0;
    bus.memread   = 1'b0;
    bus.dataadr   = 32'h0;
    bus.writedata = 32'h0;
    bus.funct3    = F_W;
    bus.log_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetValid", 32'(bus.log_valid), 32'h0);
    checkOutput("resetCount", 32'(bus.log_count), 32'h0);
    checkOutput("resetOverflow", 32'(bus.log_overflow), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] store then load same word");
    applyStimulus(1, 0, 32'd100, 32'd25, F_W, 0);
    applyStimulus(0, 1, 32'd100, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t1Readdata", bus.readdata, 32'd25);
    checkOutput("t1Count", 32'(bus.log_count), 32'd1);
    checkOutput("t1HeadAddr", bus.log_addr, 32'd100);
    checkOutput("t1HeadData", bus.log_data, 32'd25);
    idleCycles(3, 1);

    $display("[TB] byte and half lanes");
    applyStimulus(1, 0, 32'd128, 32'hFFFF_FFFF, F_W, 0);
    applyStimulus(1, 0, 32'd129, 32'hABCD_125A, F_B, 0);
    applyStimulus(0, 1, 32'd129, 32'h0, F_B, 0);
    @(negedge clk);
    checkOutput("t2LB129", bus.readdata, 32'h0000_005A);
    applyStimulus(0, 1, 32'd128, 32'h0, F_BU, 0);
    @(negedge clk);
    checkOutput("t2LBU128", bus.readdata, 32'h0000_00FF);
    applyStimulus(0, 1, 32'd128, 32'h0, F_B, 0);
    @(negedge clk);
    checkOutput("t2LB128", bus.readdata, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 32'd128, 32'h0, F_H, 0);
    @(negedge clk);
    checkOutput("t2LH128", bus.readdata, 32'h0000_5AFF);
    applyStimulus(0, 1, 32'd130, 32'h0, F_H, 0);
    @(negedge clk);
    checkOutput("t2LH130", bus.readdata, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 32'd128, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t2LW128", bus.readdata, 32'hFFFF_5AFF);
    checkOutput("t2Count", 32'(bus.log_count), 32'd2);
    applyStimulus(0, 0, 32'h0, 32'h0, F_W, 1);
    applyStimulus(0, 0, 32'h0, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t2HeadAddr", bus.log_addr, 32'd129);
    checkOutput("t2HeadMasked", bus.log_data, 32'h0000_005A);
    idleCycles(3, 1);

    $display("[TB] misaligned accesses");
    applyStimulus(1, 0, 32'd102, 32'hFFFF_1234, F_H, 0);
    applyStimulus(1, 0, 32'd101, 32'h0000_5555, F_H, 0);
    @(negedge clk);
    checkOutput("t3MisSH101", 32'(bus.misaligned), 32'h1);
    applyStimulus(1, 0, 32'd130, 32'h6666_6666, F_W, 0);
    @(negedge clk);
    checkOutput("t3MisSW130", 32'(bus.misaligned), 32'h1);
    applyStimulus(0, 1, 32'd101, 32'h0, F_H, 0);
    @(negedge clk);
    checkOutput("t3MisLH101", 32'(bus.misaligned), 32'h1);
    checkOutput("t3MisLoadData", bus.readdata, 32'h0);
    applyStimulus(0, 1, 32'd100, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t3LW100", bus.readdata, 32'h1234_0019);
    checkOutput("t3Count", 32'(bus.log_count), 32'd1);
    applyStimulus(0, 1, 32'd128, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t3LW128Kept", bus.readdata, 32'hFFFF_5AFF);
    idleCycles(3, 1);

    $display("[TB] FIFO fill and overflow");
    for (int i = 0; i < 17; i++) applyStimulus(1, 0, 32'(4 * i), 32'(i + 1), F_W, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t4Count", 32'(bus.log_count), 32'd16);
    checkOutput("t4Overflow", 32'(bus.log_overflow), 32'h1);
    checkOutput("t4HeadAddr", bus.log_addr, 32'd0);
    applyStimulus(1, 0, 32'd200, 32'h77, F_W, 1);
    applyStimulus(0, 0, 32'h0, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t4CountFullPop", 32'(bus.log_count), 32'd16);
    checkOutput("t4HeadAfterPop", bus.log_data, 32'd2);
    idleCycles(20, 1);
    @(negedge clk);
    checkOutput("t4Drained", 32'(bus.log_count), 32'd0);

    $display("[TB] ordered drain with toggling ready");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 32'(100 + 4 * i), 32'(32'hA0 + i), F_W, 0);
    pops = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, 0, 32'h0, 32'h0, F_W, c[0]);
      @(negedge clk);
      if (bus.log_valid && bus.log_ready) begin
        checkOutput("t5PopAddr", bus.log_addr, 32'(100 + 4 * pops));
        checkOutput("t5PopData", bus.log_data, 32'(32'hA0 + pops));
        pops++;
      end
    end
    checkOutput("t5PopTotal", 32'(pops), 32'd10);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'(40 + 4 * i), 32'(32'h11 * (i + 1)), F_W, 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.memwrite  = 1'b1;
    bus.memread   = 1'b0;
    bus.dataadr   = 32'd100;
    bus.writedata = 32'hDEAD_BEEF;
    bus.funct3    = F_W;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.memwrite  = 1'b0;
    bus.memread   = 1'b1;
    @(negedge clk);
    checkOutput("t7NoWriteInReset", bus.readdata, 32'h0000_00A0);
    checkOutput("t7Valid", 32'(bus.log_valid), 32'h0);
    checkOutput("t7Overflow", 32'(bus.log_overflow), 32'h0);

`ifdef DMEM_TOHOST_EN
    $display("[TB] tohost register");
    applyStimulus(1, 0, 32'h0000_00FC, 32'd1, F_W, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t6Done", 32'(tohostDone), 32'h1);
    checkOutput("t6Code", tohostCode, 32'd1);
    checkOutput("t6LogUnchanged", 32'(bus.log_count), 32'd0);
    applyStimulus(1, 0, 32'h0000_00FC, 32'd7, F_W, 0);
    applyStimulus(1, 0, 32'h0000_00FC, 32'h3C, F_B, 0);
    applyStimulus(0, 1, 32'h0000_00FC, 32'h0, F_BU, 0);
    @(negedge clk);
    checkOutput("t6CodeOverwrite", tohostCode, 32'd7);
    checkOutput("t6ByteIsMemory", bus.readdata, 32'h3C);
    checkOutput("t6ByteLogged", 32'(bus.log_count), 32'd1);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.memread  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6ResetDone", 32'(tohostDone), 32'h0);
    checkOutput("t6ResetValid", 32'(bus.log_valid), 32'h0);
`else
    $display("[TB] tohost address as plain memory");
    applyStimulus(1, 0, 32'h0000_00FC, 32'd1, F_W, 0);
    applyStimulus(0, 1, 32'h0000_00FC, 32'h0, F_W, 0);
    @(negedge clk);
    checkOutput("t6PlainRead", bus.readdata, 32'd1);
    checkOutput("t6PlainLogged", 32'(bus.log_count), 32'd1);
    checkOutput("t6PlainHead", bus.log_addr, 32'h0000_00FC);
`endif

    idleCycles(2, 1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
